// File: rtl/hsv_pkg.sv
// Shared types and constants for the HSV mixer front-panel controller.
package hsv_pkg;

   typedef enum logic [1:0] {
      CH_H = 2'd0,
      CH_S = 2'd1,
      CH_V = 2'd2
   } ch_t;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT,
      LOCK
   } step_state_t;

   // Reset values are held at the widest supported setpoint and truncated by the user.
   localparam int unsigned SETPOINT_MAX_W = 32;
   typedef logic [SETPOINT_MAX_W-1:0] setpoint_wide_t;

   localparam setpoint_wide_t HUE_RST_WIDE = '0;
   localparam setpoint_wide_t SAT_RST_WIDE = '1;

   function automatic setpoint_wide_t val_rst_wide(input int unsigned w);
      return setpoint_wide_t'(1) << (w - 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic ch_t next_ch(input ch_t c);
      case (c)
         CH_H:    return CH_S;
         CH_S:    return CH_V;
         default: return CH_H;
      endcase
   endfunction

endpackage

// File: rtl/hsv_step_alu.sv
// Next-value logic for one setpoint step: hue wraps, saturation and value clamp.
module hsv_step_alu
   import hsv_pkg::*;
#(
   parameter int unsigned VAL_W = 8
) (
   input  logic [VAL_W-1:0] value,
   input  logic             dir,
   input  ch_t              channel,
   output logic [VAL_W-1:0] next_value,
   output logic             changed
);

   always_comb begin
      next_value = value;
      if (channel == CH_H) begin
         next_value = dir ? value + 1'b1 : value - 1'b1;
      end else if (dir) begin
         if (value != '1) next_value = value + 1'b1;
      end else begin
         if (value != '0) next_value = value - 1'b1;
      end
      changed = (next_value != value);
   end

endmodule

// File: rtl/hsv_button_ctrl.sv
// Front-panel controller: sample-tick prescaler, button edge detect,
// press / hold-to-repeat step FSM and the H/S/V setpoint registers.
module hsv_button_ctrl
   import hsv_pkg::*;
#(
   parameter int unsigned VAL_W        = 8,
   parameter int unsigned TICK_DIV     = 1000,
   parameter int unsigned REPEAT_DELAY = 50,
   parameter int unsigned REPEAT_RATE  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_sel,
   input  logic             btn_up,
   input  logic             btn_down,
   output logic             sample_tick,
   output logic [1:0]       ch_sel,
   output logic [VAL_W-1:0] hue,
   output logic [VAL_W-1:0] sat,
   output logic [VAL_W-1:0] val,
   output logic             update
);

   localparam int unsigned PRESC_W = $clog2(TICK_DIV);
   localparam int unsigned CNT_W   = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0]   RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

   localparam logic [VAL_W-1:0] HUE_RST = HUE_RST_WIDE[VAL_W-1:0];
   localparam logic [VAL_W-1:0] SAT_RST = SAT_RST_WIDE[VAL_W-1:0];
   localparam logic [VAL_W-1:0] VAL_RST = VAL_W'(val_rst_wide(VAL_W));

   logic [PRESC_W-1:0] presc;

   always_ff @(posedge clk) begin
      if (reset || presc == PRESC_LAST) presc <= '0;
      else                              presc <= presc + 1'b1;
   end

   assign sample_tick = (presc == PRESC_LAST);

   // Bit order {sel, up, down}. A button only arms once seen low after reset,
   // so a level held through reset never produces an edge.
   logic [2:0] btn_now;
   logic [2:0] btn_q;
   logic [2:0] arm_q;
   logic [2:0] rise;
   logic       sel_rise;
   logic       up_rise;
   logic       down_rise;

   assign btn_now = {btn_sel, btn_up, btn_down};

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q <= '0;
         arm_q <= '0;
      end else begin
         btn_q <= btn_now;
         arm_q <= arm_q | ~btn_now;
      end
   end

   assign rise      = btn_now & ~btn_q & arm_q;
   assign sel_rise  = rise[2];
   assign up_rise   = rise[1];
   assign down_rise = rise[0];

   step_state_t      state;
   ch_t              ch_q;
   logic             dir_q;
   logic [CNT_W-1:0] tick_cnt;

   logic             active_held;
   logic             other_held;
   logic             hold_ok;
   logic             step_fire;
   logic             alu_dir;
   logic [VAL_W-1:0] cur_val;
   logic [VAL_W-1:0] nxt_val;
   logic             alu_changed;

   assign active_held = dir_q ? btn_up   : btn_down;
   assign other_held  = dir_q ? btn_down : btn_up;
   assign hold_ok     = active_held && !other_held;
   assign alu_dir     = (state == IDLE) ? up_rise : dir_q;

   always_comb begin
      step_fire = 1'b0;
      if (!sel_rise) begin
         case (state)
            IDLE:    step_fire = up_rise ^ down_rise;
            DELAY:   step_fire = hold_ok && sample_tick && (tick_cnt == DELAY_LAST);
            REPEAT:  step_fire = hold_ok && sample_tick && (tick_cnt == RATE_LAST);
            default: step_fire = 1'b0;
         endcase
      end
   end

   always_comb begin
      cur_val = val;
      case (ch_q)
         CH_H:    cur_val = hue;
         CH_S:    cur_val = sat;
         default: cur_val = val;
      endcase
   end

   hsv_step_alu #(
      .VAL_W (VAL_W)
   ) u_step_alu (
      .value      (cur_val),
      .dir        (alu_dir),
      .channel    (ch_q),
      .next_value (nxt_val),
      .changed    (alu_changed)
   );

   // A select edge overrides any step decision made in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ch_q     <= CH_H;
         dir_q    <= 1'b0;
         tick_cnt <= '0;
         hue      <= HUE_RST;
         sat      <= SAT_RST;
         val      <= VAL_RST;
         update   <= 1'b0;
      end else begin
         update <= 1'b0;
         if (sel_rise) begin
            ch_q  <= next_ch(ch_q);
            state <= LOCK;
         end else begin
            case (state)
               IDLE: begin
                  if (up_rise && down_rise) begin
                     state <= LOCK;
                  end else if (up_rise || down_rise) begin
                     state    <= DELAY;
                     dir_q    <= up_rise;
                     tick_cnt <= '0;
                  end
               end
               DELAY, REPEAT: begin
                  if (!active_held) begin
                     state <= IDLE;
                  end else if (other_held) begin
                     state <= LOCK;
                  end else if (sample_tick) begin
                     if (step_fire) begin
                        tick_cnt <= '0;
                        state    <= REPEAT;
                     end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  if (!btn_up && !btn_down) state <= IDLE;
               end
            endcase
         end

         if (step_fire && alu_changed) begin
            update <= 1'b1;
            case (ch_q)
               CH_H:    hue <= nxt_val;
               CH_S:    sat <= nxt_val;
               default: val <= nxt_val;
            endcase
         end
      end
   end

   assign ch_sel = ch_q;

endmodule
